// File: rtl/imem_axil.sv
// AXI-lite read-only 64-bit instruction memory with backdoor byte writes; one outstanding read.
// AR accept to RVALID takes 1+LATENCY cycles; RVALID/RDATA/RRESP hold until RREADY and ARREADY stays low meanwhile.
module imem_axil #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ARVALID,
    input  logic [31:0] ARADDR,
    output logic        ARREADY,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    input  logic        bd_wen,
    input  logic [31:0] bd_addr,
    input  logic [63:0] bd_wdata,
    input  logic [7:0]  bd_wstrb
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(8 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [63:0] r_mem [DEPTH_WORDS];

    logic          w_ar_hs;
    logic          w_enter_resp;
    logic [31:0]   w_rd_addr;
    logic [31:0]   w_rd_off;
    logic [31:0]   w_bd_off;
    logic          w_rd_ok;
    logic          w_bd_ok;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_bd_idx;
    logic          w_unused_bits;

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = 64'd0;
    end

    assign ARREADY  = (r_state == S_IDLE) && !rst;
    assign RVALID   = (r_state == S_RESP);
    assign w_ar_hs  = ARVALID && ARREADY;

    // With zero latency the array is sampled on the accept edge, before r_addr holds the address.
    assign w_rd_addr = (r_state == S_IDLE) ? ARADDR : r_addr;
    assign w_rd_off  = w_rd_addr - BASE_ADDR;
    assign w_bd_off  = bd_addr - BASE_ADDR;
    assign w_rd_ok   = ({1'b0, w_rd_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_rd_addr} < LIMIT);
    assign w_bd_ok   = ({1'b0, bd_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, bd_addr} < LIMIT);
    assign w_rd_idx  = w_rd_off[AW+2:3];
    assign w_bd_idx  = w_bd_off[AW+2:3];
    assign w_unused_bits = &{1'b0, w_rd_off[31:AW+3], w_rd_off[2:0], w_bd_off[31:AW+3], w_bd_off[2:0]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_ar_hs) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  if (RREADY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_ar_hs) begin
                r_addr <= ARADDR;
                r_cnt  <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response register; nonblocking update gives read-before-write against the backdoor.
    always_ff @(posedge clk) begin
        if (rst) begin
            RDATA <= 64'd0;
            RRESP <= 2'b00;
        end else if (w_enter_resp) begin
            if (w_rd_ok) begin
                RDATA <= r_mem[w_rd_idx];
                RRESP <= 2'b00;
            end else begin
                RDATA <= 64'd0;
                RRESP <= 2'b10;
            end
        end
    end

    // Contents deliberately survive rst.
    always_ff @(posedge clk) begin
        if (bd_wen && w_bd_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (bd_wstrb[i]) r_mem[w_bd_idx][8*i +: 8] <= bd_wdata[8*i +: 8];
            end
        end
    end

endmodule
